tt_um_random_pulse_generator: RTL and testbench

//   LFSR-based random pulse generator for a TinyTapeout tile. Each enabled clock emits a
//   1-cycle pulse with probability R*16/256, where R (0..15) is the rate selection.
//   R comes from ui_in[3:0], or from a rotary-encoder rate register when ui_in[3:0]==0.

---
 rtl/tt_um_random_pulse_generator_if.sv | 21 ++
 rtl/tt_um_random_pulse_generator.sv | 114 +++++++++++
 tb/tb_tt_um_random_pulse_generator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tt_um_random_pulse_generator_if.sv
// tt_um_random_pulse_generator_if: TinyTapeout pin bundle plus rotary-encoder phases
interface tt_um_random_pulse_generator_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       clk_in;
    logic       dt_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in, clk_in, dt_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in, clk_in, dt_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_random_pulse_generator.sv
// tt_um_random_pulse_generator: LFSR random pulse generator with encoder-selectable rate
module tt_um_random_pulse_generator #(
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [3:0]  RATE_RESET      = 4'd8
) (
    input logic clk,
    input logic rst_n,
    tt_um_random_pulse_generator_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [15:0]   lfsr, lfsr_next;
    logic          pulse, toggle, dir, fire;
    logic [7:0]    count, thr;
    logic [3:0]    enc_rate, rate;
    logic [1:0]    a_sync, b_sync;
    logic [DW-1:0] a_cnt, b_cnt;
    logic          a_db, b_db, a_prev, a_rise;
    logic          unused_ok;

    // next LFSR value, effective rate and the fire decision on the pre-advance LFSR
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        rate      = (bus.ui_in[3:0] != 4'd0) ? bus.ui_in[3:0] : enc_rate;
        thr       = {rate, 4'b0000};
        fire      = bus.ena && (lfsr[7:0] < thr);
        a_rise    = a_db && !a_prev;
    end

    // LFSR advance, registered pulse, toggle and wrapping pulse counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr   <= LFSR_SEED;
            pulse  <= 1'b0;
            toggle <= 1'b0;
            count  <= 8'd0;
        end else begin
            if (bus.ena) lfsr <= lfsr_next;
            pulse <= fire;
            if (fire) begin
                toggle <= ~toggle;
                count  <= count + 8'd1;
            end
        end
    end

    // two-flop synchronizers for the asynchronous encoder phases
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
        end else begin
            a_sync <= {a_sync[0], bus.clk_in};
            b_sync <= {b_sync[0], bus.dt_in};
        end
    end

    // debounce phase A: accept a new level once it has persisted DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_cnt <= '0;
            a_db  <= 1'b0;
        end else if (a_sync[1] == a_db) begin
            a_cnt <= '0;
        end else if (a_cnt == DB_LAST) begin
            a_cnt <= '0;
            a_db  <= a_sync[1];
        end else begin
            a_cnt <= a_cnt + DW'(1);
        end
    end

    // debounce phase B with the same acceptance rule
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            b_cnt <= '0;
            b_db  <= 1'b0;
        end else if (b_sync[1] == b_db) begin
            b_cnt <= '0;
        end else if (b_cnt == DB_LAST) begin
            b_cnt <= '0;
            b_db  <= b_sync[1];
        end else begin
            b_cnt <= b_cnt + DW'(1);
        end
    end

    // quadrature decode on rising A: B low steps the rate up, B high steps it down
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_prev   <= 1'b0;
            dir      <= 1'b0;
            enc_rate <= RATE_RESET;
        end else begin
            a_prev <= a_db;
            if (a_rise) begin
                if (!b_db) begin
                    dir <= 1'b1;
                    if (enc_rate != 4'd15) enc_rate <= enc_rate + 4'd1;
                end else begin
                    dir <= 1'b0;
                    if (enc_rate != 4'd0) enc_rate <= enc_rate - 4'd1;
                end
            end
        end
    end

    assign bus.uo_out  = {rate, bus.ena, dir, toggle, pulse};
    assign bus.uio_out = count;
    assign bus.uio_oe  = 8'hFF;
    assign unused_ok   = &{1'b0, bus.ui_in[7:4], bus.uio_in};
endmodule

// File: tb/tb_tt_um_random_pulse_generator.sv
// tb_tt_um_random_pulse_generator: scoreboard bench driving the pulse generator against a cycle model
module tb_tt_um_random_pulse_generator;
    logic clk = 1'b0;
    logic rst_n;

    tt_um_random_pulse_generator_if bus();

    tt_um_random_pulse_generator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] exp;
        logic [15:0] mask;
    } sb_t;

    sb_t         sb[$];
    int          vectors = 0;
    int          errors  = 0;
    int          hits    = 0;
    int          total   = 0;
    logic [15:0] mask    = 16'hFFFF;
    logic [15:0] m_lfsr;
    logic        m_pulse, m_tog, m_dir;
    logic [7:0]  m_cnt;
    logic [3:0]  m_enc;

    task automatic mreset();
        m_lfsr  = 16'hACE1;
        m_pulse = 1'b0;
        m_tog   = 1'b0;
        m_dir   = 1'b0;
        m_cnt   = 8'd0;
        m_enc   = 4'd8;
    endtask

    function automatic logic [3:0] eff();
        return (bus.ui_in[3:0] != 4'd0) ? bus.ui_in[3:0] : m_enc;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input int val, input int lo, input int hi);
        vectors++;
        assert (val >= lo && val <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic cyc();
        sb_t  e;
        logic f;
        f = bus.ena && (m_lfsr[7:0] < {eff(), 4'b0000});
        if (bus.ena) m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m_pulse = f;
        if (f) begin
            m_tog = ~m_tog;
            m_cnt = m_cnt + 8'd1;
        end
        e.exp  = {eff(), bus.ena, m_dir, m_tog, m_pulse, m_cnt};
        e.mask = mask;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("cycle", {16'h0, {bus.uo_out, bus.uio_out} & e.mask}, {16'h0, e.exp & e.mask});
        if (bus.uo_out[0]) begin
            hits++;
            total++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic detent_cw();
        bus.clk_in = 1'b1;
        run(10);
        bus.clk_in = 1'b0;
        run(10);
        m_enc = (m_enc == 4'd15) ? 4'd15 : m_enc + 4'd1;
        m_dir = 1'b1;
    endtask

    task automatic detent_ccw();
        bus.dt_in = 1'b1;
        run(10);
        bus.clk_in = 1'b1;
        run(10);
        bus.clk_in = 1'b0;
        run(10);
        bus.dt_in = 1'b0;
        run(10);
        m_enc = (m_enc == 4'd0) ? 4'd0 : m_enc - 4'd1;
        m_dir = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b1;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        bus.clk_in = 1'b0;
        bus.dt_in  = 1'b0;
        mreset();
        @(posedge clk);
        #1;
        check("reset_uo_out", {24'h0, bus.uo_out}, 32'h80);
        check("reset_uio_out", {24'h0, bus.uio_out}, 32'h00);
        check("reset_uio_oe", {24'h0, bus.uio_oe}, 32'hFF);
        #2;
        rst_n = 1'b0;

        bus.ena   = 1'b1;
        bus.ui_in = 8'h0F;
        hits      = 0;
        cyc();
        check("first_fire", {31'h0, bus.uo_out[0]}, 32'h1);
        check("rate_f", {28'h0, bus.uo_out[7:4]}, 32'hF);
        run(999);
        check_range("r15_pulses", hits, 887, 987);
        check("r15_count", {24'h0, bus.uio_out}, {24'h0, total[7:0]});

        bus.ui_in = 8'h01;
        hits      = 0;
        run(1000);
        check_range("r1_pulses", hits, 12, 112);
        check("r1_count", {24'h0, bus.uio_out}, {24'h0, total[7:0]});

        bus.ui_in = 8'h05;
        hits      = 0;
        run(1000);
        check_range("r5_pulses", hits, 262, 362);
        check("r5_count", {24'h0, bus.uio_out}, {24'h0, total[7:0]});

        bus.ena = 1'b0;
        hits    = 0;
        run(50);
        check("ena0_quiet", hits, 0);

        bus.ena   = 1'b1;
        bus.ui_in = 8'h00;
        run(200);
        check("r8_count", {24'h0, bus.uio_out}, {24'h0, total[7:0]});

        bus.ui_in = 8'h0F;
        mask      = 16'hFBFF;
        for (int i = 0; i < 3; i++) detent_cw();
        mask      = 16'hFFFF;
        bus.ena   = 1'b0;
        bus.ui_in = 8'h00;
        run(2);
        check("cw_rate", {28'h0, bus.uo_out[7:4]}, 32'd11);
        check("cw_dir", {31'h0, bus.uo_out[2]}, 32'h1);

        mask = 16'h0BFF;
        for (int i = 0; i < 12; i++) detent_ccw();
        mask = 16'hFFFF;
        run(2);
        check("ccw_rate", {28'h0, bus.uo_out[7:4]}, 32'd0);
        check("ccw_dir", {31'h0, bus.uo_out[2]}, 32'h0);

        bus.ena    = 1'b1;
        bus.clk_in = 1'b1;
        run(2);
        bus.clk_in = 1'b0;
        hits       = 0;
        run(100);
        check("glitch_rate", {28'h0, bus.uo_out[7:4]}, 32'd0);
        check("r0_quiet", hits, 0);

        bus.ui_in = 8'h0F;
        run(20);
        check("count_nonzero", {31'h0, bus.uio_out != 8'h00}, 32'h1);
        bus.ui_in = 8'h00;
        #2;
        rst_n = 1'b1;
        #1;
        check("async_count", {24'h0, bus.uio_out}, 32'h00);
        check("async_uo_out", {24'h0, bus.uo_out}, 32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
